// File: rtl/milano_pkg.sv
//------------------------------------------------------------------------------
// Module      : milano_pkg
// Description : Shared types and constants for the multiply/divide sequencer.
// Revision    : 1.0
//------------------------------------------------------------------------------
`default_nettype none

package milano_pkg;

    typedef enum logic [2:0] {
        MD_OP_MUL   = 3'd0,
        MD_OP_MULH  = 3'd1,
        MD_OP_MULSU = 3'd2,
        MD_OP_MULU  = 3'd3,
        MD_OP_DIV   = 3'd4,
        MD_OP_DIVU  = 3'd5,
        MD_OP_REM   = 3'd6,
        MD_OP_REMU  = 3'd7
    } md_opt_e;

    typedef enum logic [2:0] {
        MD_ST_IDLE      = 3'd0,
        MD_ST_MUL       = 3'd1,
        MD_ST_DIV_START = 3'd2,
        MD_ST_DIV_WAIT  = 3'd3,
        MD_ST_RESP      = 3'd4,
        MD_ST_DRAIN     = 3'd5
    } md_ctrl_state_e;

    localparam logic [31:0] MD_DIV0_QUOT = 32'hFFFF_FFFF;
    localparam logic [31:0] MD_INT_MIN   = 32'h8000_0000;

    function automatic logic is_div_op(input md_opt_e op);
        return (op == MD_OP_DIV) || (op == MD_OP_DIVU) ||
               (op == MD_OP_REM) || (op == MD_OP_REMU);
    endfunction

endpackage

`default_nettype wire

// File: rtl/md_div_special.sv
//------------------------------------------------------------------------------
// Module      : md_div_special
// Description : Detects divide-by-zero and signed overflow, giving the result.
// Revision    : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module md_div_special
    import milano_pkg::*;
(
    input  md_opt_e     op_i,
    input  logic [31:0] a_i,
    input  logic [31:0] b_i,
    output logic        is_special_o,
    output logic [31:0] special_result_o
);

    logic w_div_zero;
    logic w_overflow;

    assign w_div_zero = (b_i == 32'd0);
    assign w_overflow = (a_i == MD_INT_MIN) && (b_i == 32'hFFFF_FFFF);

    always_comb begin
        is_special_o     = 1'b0;
        special_result_o = 32'd0;
        if (is_div_op(op_i)) begin
            if (w_div_zero) begin
                is_special_o     = 1'b1;
                special_result_o = ((op_i == MD_OP_DIV) || (op_i == MD_OP_DIVU)) ? MD_DIV0_QUOT : a_i;
            end else if (w_overflow && ((op_i == MD_OP_DIV) || (op_i == MD_OP_REM))) begin
                is_special_o     = 1'b1;
                special_result_o = (op_i == MD_OP_DIV) ? MD_INT_MIN : 32'd0;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/md_seq_ctrl.sv
//------------------------------------------------------------------------------
// Module      : md_seq_ctrl
// Description : Sequences one M-extension op through the mul/div datapath.
// Revision    : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module md_seq_ctrl
    import milano_pkg::*;
#(
    parameter int MUL_LATENCY = 1,
    parameter int DIV_TIMEOUT = 40
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  md_opt_e     req_op_i,
    input  logic [31:0] req_a_i,
    input  logic [31:0] req_b_i,
    input  logic [4:0]  req_rd_addr_i,
    input  logic        req_rd_we_i,
    input  logic        flush_i,
    output logic        stall_o,
    output md_opt_e     md_operate_o,
    output logic [31:0] md_operand_a_o,
    output logic [31:0] md_operand_b_o,
    output logic        div_start_o,
    input  logic        div_done_i,
    input  logic        div_busy_i,
    input  logic [31:0] md_wdata_i,
    output logic        wb_valid_o,
    output logic        wb_we_o,
    output logic [4:0]  wb_rd_addr_o,
    output logic [31:0] wb_wdata_o,
    output logic        timeout_o
);

    localparam int c_CNT_W = $clog2(DIV_TIMEOUT + 1);

    md_ctrl_state_e     r_state, w_state_nxt;
    logic [c_CNT_W-1:0] r_cnt, w_cnt_nxt;
    md_opt_e            r_op;
    logic [31:0]        r_a, r_b, r_wdata, w_wdata_nxt;
    logic [4:0]         r_rd;
    logic               r_we;
    logic               w_accept, w_load_wdata, w_timeout;
    logic               w_is_special;
    logic [31:0]        w_special_result;

    // Fast-path decision is made on the incoming request, before it is latched.
    md_div_special u_div_special (
        .op_i             (req_op_i),
        .a_i              (req_a_i),
        .b_i              (req_b_i),
        .is_special_o     (w_is_special),
        .special_result_o (w_special_result)
    );

    assign req_ready_o = (r_state == MD_ST_IDLE) && !flush_i;
    assign w_accept    = req_valid_i && req_ready_o;

    always_comb begin
        w_state_nxt  = r_state;
        w_cnt_nxt    = r_cnt;
        w_load_wdata = 1'b0;
        w_wdata_nxt  = md_wdata_i;
        w_timeout    = 1'b0;
        case (r_state)
            MD_ST_IDLE: begin
                if (w_accept) begin
                    if (!is_div_op(req_op_i)) begin
                        w_state_nxt = MD_ST_MUL;
                        w_cnt_nxt   = c_CNT_W'(MUL_LATENCY - 1);
                    end else if (w_is_special) begin
                        w_state_nxt  = MD_ST_RESP;
                        w_load_wdata = 1'b1;
                        w_wdata_nxt  = w_special_result;
                    end else begin
                        w_state_nxt = MD_ST_DIV_START;
                    end
                end
            end
            MD_ST_MUL: begin
                if (flush_i) begin
                    w_state_nxt = MD_ST_IDLE;
                end else if (r_cnt == '0) begin
                    w_state_nxt  = MD_ST_RESP;
                    w_load_wdata = 1'b1;
                end else begin
                    w_cnt_nxt = r_cnt - 1'b1;
                end
            end
            MD_ST_DIV_START: begin
                // The start pulse has already gone out, so a flush must drain.
                w_state_nxt = flush_i ? MD_ST_DRAIN : MD_ST_DIV_WAIT;
                w_cnt_nxt   = '0;
            end
            MD_ST_DIV_WAIT: begin
                if (flush_i) begin
                    w_state_nxt = MD_ST_DRAIN;
                end else if (div_done_i) begin
                    w_state_nxt  = MD_ST_RESP;
                    w_load_wdata = 1'b1;
                end else if (r_cnt == c_CNT_W'(DIV_TIMEOUT - 1)) begin
                    w_state_nxt = MD_ST_DRAIN;
                    w_timeout   = 1'b1;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            MD_ST_RESP: begin
                w_state_nxt = MD_ST_IDLE;
            end
            MD_ST_DRAIN: begin
                if (div_done_i || !div_busy_i) begin
                    w_state_nxt = MD_ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = MD_ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= MD_ST_IDLE;
            r_cnt   <= '0;
            r_op    <= MD_OP_MUL;
            r_a     <= '0;
            r_b     <= '0;
            r_rd    <= '0;
            r_we    <= 1'b0;
            r_wdata <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            if (w_accept) begin
                r_op <= req_op_i;
                r_a  <= req_a_i;
                r_b  <= req_b_i;
                r_rd <= req_rd_addr_i;
                r_we <= req_rd_we_i;
            end
            if (w_load_wdata) begin
                r_wdata <= w_wdata_nxt;
            end
        end
    end

    assign stall_o        = req_valid_i && !req_ready_o;
    assign md_operate_o   = r_op;
    assign md_operand_a_o = r_a;
    assign md_operand_b_o = r_b;
    assign div_start_o    = (r_state == MD_ST_DIV_START);
    assign wb_valid_o     = (r_state == MD_ST_RESP) && !flush_i;
    assign wb_we_o        = wb_valid_o && r_we;
    assign wb_rd_addr_o   = r_rd;
    assign wb_wdata_o     = r_wdata;
    assign timeout_o      = w_timeout;

    a_no_done_in_start: assert property (@(posedge clk_i) disable iff (rst_i)
        (r_state == MD_ST_DIV_START) |-> !div_done_i);

endmodule

`default_nettype wire
